// File: rtl/is_array_pkg.sv
// Shared constants and helpers for the input-stationary array output path.
// Lane values are handled in a 64-bit container, so WIDTH_MAC must not exceed 64.
package is_array_pkg;

  localparam int IS_WIDTH_MAC = 48;
  localparam int IS_WIDTH_OUT = 32;

  function automatic int clog2(input int unsigned value);
    int result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Clamp an already shifted, already sign/zero-extended lane to 'width' bits.
  function automatic logic [63:0] sat_narrow(input logic [63:0] value,
                                             input int unsigned width,
                                             input logic is_signed);
    logic signed [63:0] sval;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic [63:0] uhi;
    logic [63:0] result;
    sval = $signed(value);
    hi = (64'sd1 <<< (width - 32'd1)) - 64'sd1;
    lo = -hi - 64'sd1;
    uhi = (width >= 32'd64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << width) - 64'd1);
    if (is_signed) begin
      if (sval > hi) begin
        result = hi;
      end else if (sval < lo) begin
        result = lo;
      end else begin
        result = value;
      end
    end else begin
      if (value > uhi) begin
        result = uhi;
      end else begin
        result = value;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/is_row_fifo.sv
// Row FIFO with wrap-bit pointers and a registered head-of-queue output.
module is_row_fifo
  import is_array_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 128
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               wdata,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [clog2(DEPTH+1)-1:0]      level
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW:0]      wr_next_s;
  logic [AW:0]      rd_next_s;
  logic [WIDTH-1:0] rdata_r;
  logic [WIDTH-1:0] head_s;
  logic             wr_en_s;
  logic             rd_en_s;
  logic             next_empty_s;

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign level = LW'(wr_ptr_r - rd_ptr_r);
  assign rdata = rdata_r;

  // A full FIFO still accepts a row when the head leaves in the same cycle.
  assign wr_en_s      = push && (!full || pop);
  assign rd_en_s      = pop && !empty;
  assign wr_next_s    = wr_ptr_r + {{AW{1'b0}}, wr_en_s};
  assign rd_next_s    = rd_ptr_r + {{AW{1'b0}}, rd_en_s};
  assign next_empty_s = (wr_next_s == rd_next_s);

  // Next head: the row being written lands exactly in the slot that becomes the head.
  always_comb begin
    head_s = mem_r[rd_next_s[AW-1:0]];
    if (wr_en_s && (rd_next_s[AW-1:0] == wr_ptr_r[AW-1:0])) begin
      head_s = wdata;
    end else begin
      head_s = mem_r[rd_next_s[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_s && !clear) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      rdata_r  <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      rdata_r  <= '0;
    end else begin
      wr_ptr_r <= wr_next_s;
      rd_ptr_r <= rd_next_s;
      if (!next_empty_s) begin
        rdata_r <= head_s;
      end
    end
  end

endmodule

// File: rtl/is_output_collector.sv
// Deskews the bottom PE row, formats each lane and queues aligned rows.
// Build option IS_COLLECT_SAT_EN: saturating narrowing instead of low-bit wrap.
module is_output_collector
  import is_array_pkg::*;
#(
  parameter int COLS      = 4,
  parameter int WIDTH_MAC = IS_WIDTH_MAC,
  parameter int WIDTH_OUT = IS_WIDTH_OUT,
  parameter int DEPTH     = 8,
  parameter int SIGNED    = 0,
  parameter int SHIFT     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          reg_clear,
  input  logic [COLS*WIDTH_MAC-1:0]     mac_in,
  input  logic [COLS-1:0]               mac_vld,
  output logic [COLS*WIDTH_OUT-1:0]     out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [clog2(DEPTH+1)-1:0]     fifo_level,
  output logic                          overflow,
  output logic                          skew_err,
  output logic                          busy
);

  logic [COLS-1:0]           al_vld_s;
  logic [WIDTH_MAC-1:0]      al_data_s [COLS];
  logic [COLS-1:0]           inflight_s;
  logic [COLS*WIDTH_OUT-1:0] row_s;
  logic                      aligned_s;
  logic                      partial_s;
  logic                      pop_s;
  logic                      full_s;
  logic                      empty_s;
  logic                      overflow_r;
  logic                      skew_err_r;

  for (genvar c = 0; c < COLS; c++) begin : g_lane
    localparam int DLY = COLS - 1 - c;
    logic [WIDTH_MAC-1:0] sh_s;

    if (DLY == 0) begin : g_comb
      assign al_vld_s[c]   = mac_vld[c];
      assign al_data_s[c]  = mac_in[c*WIDTH_MAC +: WIDTH_MAC];
      assign inflight_s[c] = 1'b0;
    end else begin : g_pipe
      logic [WIDTH_MAC-1:0] data_r [DLY];
      logic [DLY-1:0]       vld_r;

      // Earlier lanes wait for the last lane so the row lines up on one edge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_r <= '0;
          for (int i = 0; i < DLY; i++) data_r[i] <= '0;
        end else if (reg_clear) begin
          vld_r <= '0;
          for (int i = 0; i < DLY; i++) data_r[i] <= '0;
        end else begin
          vld_r[0]  <= mac_vld[c];
          data_r[0] <= mac_in[c*WIDTH_MAC +: WIDTH_MAC];
          for (int i = 1; i < DLY; i++) begin
            vld_r[i]  <= vld_r[i-1];
            data_r[i] <= data_r[i-1];
          end
        end
      end

      assign al_vld_s[c]   = vld_r[DLY-1];
      assign al_data_s[c]  = data_r[DLY-1];
      assign inflight_s[c] = |vld_r;
    end

    if (SIGNED != 0) begin : g_sshift
      assign sh_s = WIDTH_MAC'($signed(al_data_s[c]) >>> SHIFT);
    end else begin : g_ushift
      assign sh_s = al_data_s[c] >> SHIFT;
    end

`ifdef IS_COLLECT_SAT_EN
    logic [63:0] ext_s;
    if (SIGNED != 0) begin : g_sext
      assign ext_s = 64'($signed(sh_s));
    end else begin : g_zext
      assign ext_s = 64'(sh_s);
    end
    assign row_s[c*WIDTH_OUT +: WIDTH_OUT] = WIDTH_OUT'(sat_narrow(ext_s, WIDTH_OUT, SIGNED != 0));
`else
    assign row_s[c*WIDTH_OUT +: WIDTH_OUT] = WIDTH_OUT'(sh_s);
`endif
  end

  assign aligned_s = &al_vld_s;
  assign partial_s = (|al_vld_s) && !aligned_s;
  assign out_valid = !empty_s;
  assign pop_s     = out_valid && out_ready;
  assign overflow  = overflow_r;
  assign skew_err  = skew_err_r;
  assign busy      = (|inflight_s) || out_valid;

  is_row_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (COLS*WIDTH_OUT)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (reg_clear),
    .push  (aligned_s),
    .pop   (pop_s),
    .wdata (row_s),
    .rdata (out_data),
    .full  (full_s),
    .empty (empty_s),
    .level (fifo_level)
  );

  // Sticky error flags: dropped full-FIFO rows and torn (partially valid) rows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r <= 1'b0;
      skew_err_r <= 1'b0;
    end else if (reg_clear) begin
      overflow_r <= 1'b0;
      skew_err_r <= 1'b0;
    end else begin
      if (aligned_s && full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end
      if (partial_s) begin
        skew_err_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_is_output_collector.sv
// Directed bench: an unsigned default instance and a signed/shifted narrow instance.
module tb_is_output_collector;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         reg_clear = 1'b0;
  logic [191:0] mac_in = '0;
  logic [3:0]   mac_vld = '0;
  logic         out_ready = 1'b0;

  logic [127:0] out_data_a;
  logic         out_valid_a, overflow_a, skew_err_a, busy_a;
  logic [3:0]   fifo_level_a;
  logic [63:0]  out_data_b;
  logic         out_valid_b, overflow_b, skew_err_b, busy_b;
  logic [3:0]   fifo_level_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  is_output_collector dut_a (
    .clk(clk), .rst(rst), .reg_clear(reg_clear), .mac_in(mac_in), .mac_vld(mac_vld),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .fifo_level(fifo_level_a), .overflow(overflow_a), .skew_err(skew_err_a), .busy(busy_a)
  );

  is_output_collector #(.WIDTH_OUT(16), .SIGNED(1), .SHIFT(4)) dut_b (
    .clk(clk), .rst(rst), .reg_clear(reg_clear), .mac_in(mac_in), .mac_vld(mac_vld),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .fifo_level(fifo_level_b), .overflow(overflow_b), .skew_err(skew_err_b), .busy(busy_b)
  );

  typedef struct {
    logic [191:0] bus;
    logic [127:0] exp_a;
    logic [63:0]  exp_b;
  } vec_t;

  vec_t vecs[3];

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] rv(input int id, input int c);
    return 48'(id * 256 + c);
  endfunction

  function automatic logic [127:0] rexp(input int id);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) r[c*32 +: 32] = 32'(id * 256 + c);
    return r;
  endfunction

  // Skewed stream of n rows; lane c carries row k-c in cycle k.
  task automatic stream(input int n, input int first_id, input int skip_row,
                        input int skip_lane, input logic rdy_last);
    for (int k = 0; k < n + 3; k++) begin
      @(posedge clk); #1;
      mac_vld = '0;
      mac_in  = '0;
      for (int c = 0; c < 4; c++) begin
        if ((k - c) >= 0 && (k - c) < n && !((k - c) == skip_row && c == skip_lane)) begin
          mac_vld[c] = 1'b1;
          mac_in[c*48 +: 48] = rv(first_id + k - c, c);
        end
      end
      if (k == n + 2) out_ready = rdy_last;
    end
    @(posedge clk); #1;
    mac_vld = '0;
    mac_in = '0;
    out_ready = 1'b0;
  endtask

  task automatic latency_row(input logic [191:0] bus, input logic [127:0] exp);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      mac_in  = bus;
      mac_vld = 4'(1 << k);
      if (k > 0) chk($sformatf("lat_valid_low_k%0d", k), 192'(out_valid_a), 192'd0);
      if (k == 1) chk("lat_busy", 192'(busy_a), 192'd1);
    end
    @(posedge clk); #1;
    mac_vld = '0;
    mac_in  = '0;
    chk("lat_valid_high", 192'(out_valid_a), 192'd1);
    chk("lat_data", 192'(out_data_a), 192'(exp));
    chk("lat_level", 192'(fifo_level_a), 192'd1);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("pop_level", 192'(fifo_level_a), 192'd0);
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    reg_clear = 1'b1;
    @(posedge clk); #1;
    reg_clear = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 192'(out_valid_a), 192'd0);
    chk({tag, "_data"}, 192'(out_data_a), 192'd0);
    chk({tag, "_data_b"}, 192'(out_data_b), 192'd0);
    chk({tag, "_level"}, 192'(fifo_level_a), 192'd0);
    chk({tag, "_ovf"}, 192'(overflow_a), 192'd0);
    chk({tag, "_skew"}, 192'(skew_err_a), 192'd0);
    chk({tag, "_busy"}, 192'(busy_a), 192'd0);
  endtask

  initial begin
    vecs[0].bus = {48'h0000_0000_0007, 48'h0000_FFFF_FFFF, 48'h0000_0000_0000, 48'h0000_1234_5678};
    vecs[1].bus = {48'hFFFF_FFFF_FFF0, 48'h0000_0001_2340, 48'hFFFF_C000_0000, 48'h0001_0000_0005};
    vecs[2].bus = {48'h0000_0007_FFF0, 48'hFFFF_FFFF_8000, 48'h0000_0010_0000, 48'h8000_0000_0000};
`ifdef IS_COLLECT_SAT_EN
    vecs[0].exp_a = {32'h0000_0007, 32'hFFFF_FFFF, 32'h0000_0000, 32'h1234_5678};
    vecs[0].exp_b = {16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF};
    vecs[1].exp_a = {32'hFFFF_FFFF, 32'h0001_2340, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[1].exp_b = {16'hFFFF, 16'h1234, 16'h8000, 16'h7FFF};
    vecs[2].exp_a = {32'h0007_FFF0, 32'hFFFF_FFFF, 32'h0010_0000, 32'hFFFF_FFFF};
    vecs[2].exp_b = {16'h7FFF, 16'hF800, 16'h7FFF, 16'h8000};
`else
    vecs[0].exp_a = {32'h0000_0007, 32'hFFFF_FFFF, 32'h0000_0000, 32'h1234_5678};
    vecs[0].exp_b = {16'h0000, 16'hFFFF, 16'h0000, 16'h4567};
    vecs[1].exp_a = {32'hFFFF_FFF0, 32'h0001_2340, 32'hC000_0000, 32'h0000_0005};
    vecs[1].exp_b = {16'hFFFF, 16'h1234, 16'h0000, 16'h0000};
    vecs[2].exp_a = {32'h0007_FFF0, 32'hFFFF_8000, 32'h0010_0000, 32'h0000_0000};
    vecs[2].exp_b = {16'h7FFF, 16'hF800, 16'h0000, 16'h0000};
`endif

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // First row: lanes 10,20,30,40 with exact COLS latency.
    latency_row({48'd40, 48'd30, 48'd20, 48'd10}, {32'd40, 32'd30, 32'd20, 32'd10});
    pop_one();

    for (int v = 0; v < 3; v++) begin
      latency_row(vecs[v].bus, vecs[v].exp_a);
      chk($sformatf("fmt_b_v%0d", v), 192'(out_data_b), 192'(vecs[v].exp_b));
      pop_one();
    end

    // Nine back-to-back rows into an 8-deep FIFO.
    stream(9, 1, -1, -1, 1'b0);
    chk("ovf_level", 192'(fifo_level_a), 192'd8);
    chk("ovf_flag", 192'(overflow_a), 192'd1);
    chk("ovf_skew", 192'(skew_err_a), 192'd0);
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      chk($sformatf("drain_valid_%0d", r), 192'(out_valid_a), 192'd1);
      chk($sformatf("drain_data_%0d", r), 192'(out_data_a), 192'(rexp(1 + r)));
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    chk("drain_empty", 192'(out_valid_a), 192'd0);
    chk("drain_sticky", 192'(overflow_a), 192'd1);
    do_clear();
    chk("clear_ovf", 192'(overflow_a), 192'd0);

    // Torn row: lane 2 missing.
    stream(1, 30, 0, 2, 1'b0);
    chk("skew_flag", 192'(skew_err_a), 192'd1);
    chk("skew_level", 192'(fifo_level_a), 192'd0);
    stream(1, 31, -1, -1, 1'b0);
    chk("skew_next_level", 192'(fifo_level_a), 192'd1);
    chk("skew_next_data", 192'(out_data_a), 192'(rexp(31)));
    chk("skew_sticky", 192'(skew_err_a), 192'd1);
    do_clear();

    // Full FIFO with a pop on the same edge as an aligned row.
    stream(8, 50, -1, -1, 1'b0);
    chk("fullpop_pre_level", 192'(fifo_level_a), 192'd8);
    chk("fullpop_hold", 192'(out_data_a), 192'(rexp(50)));
    stream(1, 60, -1, -1, 1'b1);
    chk("fullpop_level", 192'(fifo_level_a), 192'd8);
    chk("fullpop_ovf", 192'(overflow_a), 192'd0);
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      chk($sformatf("fullpop_data_%0d", r), 192'(out_data_a), 192'(rexp(r < 7 ? 51 + r : 60)));
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    chk("fullpop_empty", 192'(out_valid_a), 192'd0);

    // Async reset with rows queued and a row in flight.
    stream(3, 70, -1, -1, 1'b0);
    chk("rst_pre_level", 192'(fifo_level_a), 192'd3);
    @(posedge clk); #1;
    mac_vld = 4'b0001;
    mac_in  = {48'd4, 48'd3, 48'd2, 48'd1};
    @(posedge clk); #1;
    mac_vld = 4'b0010;
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    mac_vld = '0;
    mac_in = '0;
    latency_row({48'd8, 48'd7, 48'd6, 48'd5}, {32'd8, 32'd7, 32'd6, 32'd5});
    pop_one();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/is_output_collector.md
Name: is_output_collector

Overview:
- Sits directly downstream of the input-stationary systolic array; consumes the MAC_out bus of the bottom PE row.
- Bottom-row results arrive column-skewed: column c is valid c cycles after column 0.
- Block removes the skew, formats each lane from WIDTH_MAC down to WIDTH_OUT, and queues whole aligned rows in a FIFO.
- FIFO drains to the writeback path over a valid/ready handshake.

Parameters:
- COLS, 4, number of array columns (lanes); must be >= 1
- WIDTH_MAC, 48, width of each incoming PE MAC result
- WIDTH_OUT, 32, width of each formatted output lane; must be <= WIDTH_MAC
- DEPTH, 8, FIFO depth in rows; power of two, >= 2
- SIGNED, 0, 1 = lanes are two's complement (arithmetic shift, signed saturation)
- SHIFT, 0, right shift applied to each lane before narrowing; 0..WIDTH_MAC-WIDTH_OUT

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- reg_clear  in  1  synchronous clear of all state; same effect as rst
- mac_in  in  COLS*WIDTH_MAC  bottom-row MAC results; lane c = bits [c*WIDTH_MAC +: WIDTH_MAC]
- mac_vld  in  COLS  per-lane valid pulse, skewed by lane index
- out_data  out  COLS*WIDTH_OUT  head-of-FIFO row, same lane packing as mac_in
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data this cycle
- fifo_level  out  $clog2(DEPTH+1)  rows currently stored
- overflow  out  1  sticky; a row was dropped because the FIFO was full
- skew_err  out  1  sticky; a partially aligned row was dropped
- busy  out  1  any deskew valid in flight OR out_valid

Behaviour:
- Reset (rst or reg_clear) values: all deskew registers 0, FIFO empty, out_valid=0, out_data=0, fifo_level=0, overflow=0, skew_err=0, busy=0. rst mid-operation discards everything immediately. reg_clear has priority over every other event in that cycle.
- Deskew: lane c passes data+valid through COLS-1-c registers; lane COLS-1 is combinational (zero registers).
- If lane 0 is valid at cycle t, every lane is aligned at cycle t+COLS-1.
- Aligned event (all delayed valids = 1): the formatted row is a push candidate at that edge.
- Partial event (some but not all delayed valids = 1): no push; skew_err set sticky.
- Formatting per lane, combinational before the FIFO write: shift right by SHIFT (arithmetic if SIGNED, else logical), then narrow to WIDTH_OUT per the Optional Feature.
- FIFO:
  - Write/read pointers with a wrap bit. Full when pointers are equal and wrap bits differ; empty when pointers and wrap bits are equal.
  - Pop when out_valid && out_ready.
  - Push accepted if not full, or if full and popping in the same cycle.
  - Push rejected when full and not popping: row dropped, overflow set sticky, FIFO contents unchanged.
  - Simultaneous push and pop: fifo_level unchanged.
  - No write-to-read bypass: a row pushed at edge N is visible on out_data/out_valid after edge N. End-to-end latency from lane-0 valid to out_valid = COLS cycles.
- out_data is registered head data; it holds stable while out_valid=1 and out_ready=0.
- out_data after the last pop: holds its last value; content is don't-care while out_valid=0.
- Back-to-back rows, one per cycle, are sustained with no bubbles while out_ready=1.

Optional Feature:
- Macro: IS_COLLECT_SAT_EN
- Defined: narrowing saturates.
  - SIGNED=1: clamp to [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1].
  - SIGNED=0: clamp to 2^WIDTH_OUT-1.
- Undefined: narrowing takes the low WIDTH_OUT bits (wrap); no clamp logic is generated.

Decomposition:
- Shared package is_array_pkg:
  - lane-width constants WIDTH_MAC / WIDTH_OUT defaults
  - function clog2
  - saturate/narrow helper function
- One sub-module: is_row_fifo (parameterised DEPTH and row width; push/pop/full/empty/level). Deskew and formatting stay in the top module.

Test Plan:
- COLS=4, SHIFT=0. Lanes carry 10,20,30,40; mac_vld lane c pulses at cycle 5+c -> out_valid rises at cycle 9 with out_data lanes {10,20,30,40}; fifo_level=1.
- Nine skewed rows streamed with out_ready=0, DEPTH=8 -> fifo_level=8; overflow=1 after the 9th aligns; draining returns rows 1..8 in order.
- Lane 2 valid omitted for one row -> skew_err=1, no push, fifo_level unchanged; the next correct row is pushed normally.
- FIFO full with out_ready=1 while a row aligns -> push and pop in the same cycle, fifo_level stays 8, overflow stays 0.
- SIGNED=1, SHIFT=4, WIDTH_OUT=16, lane = -2^30:
  - IS_COLLECT_SAT_EN defined -> lane = -32768.
  - IS_COLLECT_SAT_EN undefined -> lane = low 16 bits of (-2^26) = 0.
- rst asserted with 3 rows queued and rows in flight -> all outputs 0 asynchronously. After deassertion, a new row emerges with exact COLS latency and no stale data.
